// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART serialiser/deserialiser.
package uart_pkg;

    // Data bits per 8N1 frame
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// Byte-level handshake between the memory-mapped peripheral block (master)
// and the UART core (slave).
interface uart_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, rx_data, rx_valid, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, rx_data, rx_valid, rx_frame_err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// Receive half of the UART: input synchroniser, mid-bit sampling FSM and
// registered byte/status outputs.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic                 sync1_q, sync2_q;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 seen_high_q, seen_high_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
    logic                 bit_end;

    assign rx_s    = sync2_q;
    assign bit_end = (cnt_q == CNT_LAST);

    // Two-flop synchroniser; resets to the idle (high) line level so no
    // spurious start is seen when reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: start detect, mid-bit sampling and stop-bit verdict.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        seen_high_d = seen_high_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // A low only counts as a start edge once the line has been
                // high, so a stuck-low stop bit is not re-read as a frame.
                if (rx_s) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    cnt_d       = '0;
                    state_d     = RX_IDLE;
                    seen_high_d = rx_s;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            seen_high_q <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            seen_high_q <= seen_high_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: inline transmit FSM plus the receive sub-module.
// One byte in flight per direction, no FIFO.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    uart_if.slave bus,
    output logic uart_tx,
    input  logic uart_rx
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;

    // Next-state logic for the transmit frame sequencer.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no branch
        // can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        // A new byte is taken when idle or in the final stop cycle, which
        // lets back-to-back frames stream without an idle gap.
        accept  = bus.tx_start && (!busy_q || done_q);
        bit_end = (cnt_q == CNT_LAST);
        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    state_d = TX_START;
                    cnt_d   = '0;
                    shift_d = bus.tx_data;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d = TX_START;
                        shift_d = bus.tx_data;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != TX_IDLE);
        done_d = (state_d == TX_STOP) && (cnt_d == CNT_LAST);
    end

    // Transmit state and registered outputs; the line resets high at once.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop updates from the
        // values present before the edge.
        if (!reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uart_tx     = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    uart_rx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .rx_i           (uart_rx),
        .rx_data_o      (bus.rx_data),
        .rx_valid_o     (bus.rx_valid),
        .rx_frame_err_o (bus.rx_frame_err)
    );

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core at 16 clocks per bit.
module tb_uart_core;

    localparam int N = 16;
    localparam int RX_LAT = 3 + N / 2 + 9 * N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_tx;
    logic rx_drive = 1'b1;
    logic loopback = 1'b0;
    logic rx_line;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e_cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    int last_ferr_cyc = 0;
    logic [7:0] rx_hist[$];

    uart_if bus ();

    assign rx_line = loopback ? uart_tx : rx_drive;

    uart_core #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (rx_line)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time receive pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every receive pulse with the edge count it appeared after.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            rx_hist.push_back(bus.rx_data);
        end
        if (bus.rx_frame_err === 1'b1) begin
            ferr_cnt      <= ferr_cnt + 1;
            last_ferr_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with tx_start already raised; checks a whole frame.
    task automatic check_tx(input logic [7:0] b, input int ignore_at,
                            input logic chain, input logic [7:0] nb);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * N; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_start = 1'b0;
            check("tx_bit", 32'(uart_tx), 32'(fr[4'(k / N)]));
            check("tx_busy", 32'(bus.tx_busy), 32'h1);
            check("tx_done", 32'(bus.tx_done), 32'(k == 10 * N - 1));
            if (k == ignore_at) begin
                bus.tx_data  = 8'hA3;
                bus.tx_start = 1'b1;
            end
            if (k == ignore_at + 1) bus.tx_start = 1'b0;
            if (k == 10 * N - 1 && chain) begin
                bus.tx_data  = nb;
                bus.tx_start = 1'b1;
            end
        end
        if (!chain) begin
            @(negedge clk);
            check("tx_busy_end", 32'(bus.tx_busy), 32'h0);
            check("tx_idle_line", 32'(uart_tx), 32'h1);
            check("tx_done_end", 32'(bus.tx_done), 32'h0);
        end
    endtask

    // Called at a negedge; the next posedge is the first to sample the start bit.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_drive = 1'b0;
        e_cyc = cyc + 1;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[3'(i)];
            repeat (N) @(negedge clk);
        end
        rx_drive = stop_bit;
        repeat (N) @(negedge clk);
        rx_drive = 1'b1;
    endtask

    initial begin
        int n;
        int base_v;
        int base_f;
        int base_h;
        logic [7:0] lb [3];
        logic [7:0] got;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h3C;
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'h1);
        check("rst_tx_busy", 32'(bus.tx_busy), 32'h0);
        check("rst_tx_done", 32'(bus.tx_done), 32'h0);
        check("rst_rx_data", 32'(bus.rx_data), 32'h0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_rx_ferr", 32'(bus.rx_frame_err), 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset asserted mid-frame on both directions
        bus.tx_data  = 8'h5A;
        bus.tx_start = 1'b1;
        rx_drive     = 1'b0;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_tx_line_low", 32'(uart_tx), 32'h0);
        check("mid_tx_busy", 32'(bus.tx_busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_uart_tx", 32'(uart_tx), 32'h1);
        check("async_rst_busy", 32'(bus.tx_busy), 32'h0);
        check("async_rst_done", 32'(bus.tx_done), 32'h0);
        check("async_rst_valid", 32'(bus.rx_valid), 32'h0);
        check("async_rst_ferr", 32'(bus.rx_frame_err), 32'h0);
        @(negedge clk);
        rx_drive = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (12 * N) @(negedge clk);
        check("post_rst_rx_data", 32'(bus.rx_data), 32'h0);
        check("post_rst_valid_cnt", valid_cnt, 0);
        check("post_rst_ferr_cnt", ferr_cnt, 0);

        // Single frame 0x55, then idle
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        check_tx(8'h55, -1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // 0x55 with an ignored request mid-frame, chained 0xA3 in the done cycle
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        check_tx(8'h55, 49, 1'b1, 8'hA3);
        check_tx(8'hA3, -1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Receive 0xC3
        base_v = valid_cnt;
        send_rx(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        check("rx_c3_count", valid_cnt, base_v + 1);
        check("rx_c3_time", last_valid_cyc, e_cyc + RX_LAT);
        check("rx_c3_data", 32'(bus.rx_data), 32'hC3);
        check("rx_c3_no_ferr", ferr_cnt, 0);

        // Short glitch on the idle line is a false start
        base_v = valid_cnt;
        rx_drive = 1'b0;
        repeat (4) @(negedge clk);
        rx_drive = 1'b1;
        repeat (3 * N) @(negedge clk);
        check("glitch_no_valid", valid_cnt, base_v);
        check("glitch_no_ferr", ferr_cnt, 0);

        // Frame 0x81 with a low stop bit
        send_rx(8'h81, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_time", last_ferr_cyc, e_cyc + RX_LAT);
        check("ferr_no_valid", valid_cnt, base_v);
        check("ferr_rx_data_held", 32'(bus.rx_data), 32'hC3);

        // Loopback: back-to-back 0x00, 0xFF, 0x3C
        loopback = 1'b1;
        repeat (10) @(negedge clk);
        base_v = valid_cnt;
        base_f = ferr_cnt;
        base_h = rx_hist.size();
        bus.tx_data  = lb[0];
        bus.tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            if (i > 0) check("lb_gapless_start", 32'(uart_tx), 32'h0);
            n = 0;
            while (bus.tx_done !== 1'b1 && n < 20 * N) begin
                @(negedge clk);
                n++;
            end
            check("lb_tx_done", 32'(bus.tx_done), 32'h1);
            if (i < 2) begin
                bus.tx_data  = lb[2'(i + 1)];
                bus.tx_start = 1'b1;
            end
        end
        repeat (2 * N) @(negedge clk);
        check("lb_valid_count", valid_cnt, base_v + 3);
        check("lb_ferr_count", ferr_cnt, base_f);
        for (int i = 0; i < 3; i++) begin
            got = (rx_hist.size() > base_h + i) ? rx_hist[base_h + i] : 8'hxx;
            check("lb_byte", 32'(got), 32'(lb[2'(i)]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
